tx_packet_ddr_stream: RTL and testbench

TX_PACKET_DDR_STREAM -- requirements
Module: tx_packet_ddr_stream

---
 rtl/tx_packet_ddr_stream_if.sv | 34 +++
 rtl/tx_packet_ddr_stream.sv | 156 +++++++++++++++
 tb/tb_tx_packet_ddr_stream.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tx_packet_ddr_stream_if.sv
// Avalon-MM read-master and TSE transmit-FIFO signal bundle for tx_packet_ddr_stream.
// The master modport is the streamer side; slave is the DDR controller / MAC side.
interface tx_packet_ddr_stream_if #(
    parameter int ADDR_W = 25,
    parameter int DATA_W = 256
);
    logic [ADDR_W-1:0] amm_addr;
    logic              amm_read;
    logic [6:0]        amm_burstcount;
    logic              amm_ready;
    logic [DATA_W-1:0] amm_readdata;
    logic              amm_readdatavalid;

    logic [7:0]        ff_tx_data;
    logic              ff_tx_sop;
    logic              ff_tx_eop;
    logic              ff_tx_wren;
    logic              ff_tx_err;
    logic              ff_tx_rdy;

    modport master (
        output amm_addr, amm_read, amm_burstcount,
        input  amm_ready, amm_readdata, amm_readdatavalid,
        output ff_tx_data, ff_tx_sop, ff_tx_eop, ff_tx_wren, ff_tx_err,
        input  ff_tx_rdy
    );

    modport slave (
        input  amm_addr, amm_read, amm_burstcount,
        output amm_ready, amm_readdata, amm_readdatavalid,
        input  ff_tx_data, ff_tx_sop, ff_tx_eop, ff_tx_wren, ff_tx_err,
        output ff_tx_rdy
    );
endinterface

// File: rtl/tx_packet_ddr_stream.sv
// Reads a length word plus payload words from DDR over Avalon-MM and streams the
// packet bytewise into the TSE transmit FIFO, buffering read data in a small FIFO.
module tx_packet_ddr_stream #(
    parameter int ADDR_W     = 25,
    parameter int DATA_W     = 256,
    parameter int LEN_W      = 11,
    parameter int MAX_PKT    = 1518,
    parameter int FIFO_WORDS = 8
) (
    input  logic                   clk_original,
    input  logic                   rst_n,
    input  logic                   cmd_send,
    input  logic [ADDR_W-1:0]      start_ram_addr,
    output logic                   busy,
    output logic                   done,
    output logic                   len_err,
    tx_packet_ddr_stream_if.master bus
);
    localparam int BPW    = DATA_W / 8;
    localparam int BIDX_W = $clog2(BPW);
    localparam int PTR_W  = $clog2(FIFO_WORDS);
    localparam int CNT_W  = LEN_W + 1;

    typedef enum logic [2:0] {
        IDLE,
        RD_LEN,
        WAIT_LEN,
        STREAM,
        FINISH
    } state_t;

    state_t             state, state_nxt;
    logic               cmd_q;
    logic [ADDR_W-1:0]  base_addr;
    logic [CNT_W-1:0]   len, words_needed, rd_issued, rd_outstanding, byte_cnt;
    logic [BIDX_W-1:0]  byte_idx, sel_idx;
    logic [DATA_W-1:0]  fifo_mem [FIFO_WORDS];
    logic [DATA_W-1:0]  head_word;
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [PTR_W:0]     fifo_cnt;
    logic               len_err_q;

    logic               cmd_edge, len_ok, rd_req, amm_read_c, pay_accept;
    logic               fifo_wr, tx_wren, byte_accept, last_byte, word_pop;
    logic [CNT_W-1:0]   len_word, words_word;

    assign cmd_edge = cmd_send & ~cmd_q;

    always_comb begin
        len_word   = CNT_W'(bus.amm_readdata[LEN_W-1:0]);
        len_ok     = (len_word != '0) && (len_word <= CNT_W'(MAX_PKT));
        words_word = (len_word + CNT_W'(BPW - 1)) / CNT_W'(BPW);
    end

    // Buffer space is reserved at issue time, so the FIFO cannot overflow.
    assign rd_req     = (state == STREAM) && (rd_issued < words_needed) &&
                        ((CNT_W'(fifo_cnt) + rd_outstanding) < CNT_W'(FIFO_WORDS));
    assign amm_read_c = (state == RD_LEN) || rd_req;
    assign pay_accept = rd_req && bus.amm_ready;
    assign fifo_wr    = (state == STREAM) && bus.amm_readdatavalid && (rd_outstanding != '0);

    assign head_word   = fifo_mem[rd_ptr];
    assign tx_wren     = (state == STREAM) && (fifo_cnt != '0);
    assign byte_accept = tx_wren && bus.ff_tx_rdy;
    assign last_byte   = (byte_cnt == len - CNT_W'(1));
    assign word_pop    = byte_accept && (last_byte || (byte_idx == BIDX_W'(BPW - 1)));
    // Flipping the low two bits walks each 32-bit lane MSB byte first.
    assign sel_idx     = byte_idx ^ BIDX_W'(3);

    assign bus.amm_read       = amm_read_c;
    assign bus.amm_burstcount = 7'd1;
    assign bus.amm_addr       = (state == RD_LEN) ? base_addr :
                                rd_req ? base_addr + ADDR_W'(1) + ADDR_W'(rd_issued) : '0;
    assign bus.ff_tx_wren     = tx_wren;
    assign bus.ff_tx_data     = tx_wren ? head_word[{sel_idx, 3'b000} +: 8] : 8'h00;
    assign bus.ff_tx_sop      = tx_wren && (byte_cnt == '0);
    assign bus.ff_tx_eop      = tx_wren && last_byte;
    assign bus.ff_tx_err      = 1'b0;

    assign busy    = (state != IDLE);
    assign done    = (state == FINISH);
    assign len_err = len_err_q;

    // NOTE: next_state gets its default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (cmd_edge) state_nxt = RD_LEN;
            RD_LEN:   if (bus.amm_ready) state_nxt = WAIT_LEN;
            WAIT_LEN: if (bus.amm_readdatavalid) state_nxt = len_ok ? STREAM : IDLE;
            STREAM:   if (byte_accept && last_byte) state_nxt = FINISH;
            FINISH:   state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_original or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cmd_q          <= 1'b0;
            base_addr      <= '0;
            len            <= '0;
            words_needed   <= '0;
            rd_issued      <= '0;
            rd_outstanding <= '0;
            byte_cnt       <= '0;
            byte_idx       <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fifo_cnt       <= '0;
            len_err_q      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cmd_q     <= cmd_send;
            len_err_q <= (state == WAIT_LEN) && bus.amm_readdatavalid && !len_ok;
            if ((state == IDLE) && cmd_edge) base_addr <= start_ram_addr;

            if ((state == WAIT_LEN) && bus.amm_readdatavalid) begin
                len            <= len_word;
                words_needed   <= words_word;
                rd_issued      <= '0;
                rd_outstanding <= '0;
                byte_cnt       <= '0;
                byte_idx       <= '0;
                wr_ptr         <= '0;
                rd_ptr         <= '0;
                fifo_cnt       <= '0;
            end else if (state == STREAM) begin
                if (pay_accept) rd_issued <= rd_issued + CNT_W'(1);
                case ({pay_accept, fifo_wr})
                    2'b10:   rd_outstanding <= rd_outstanding + CNT_W'(1);
                    2'b01:   rd_outstanding <= rd_outstanding - CNT_W'(1);
                    default: rd_outstanding <= rd_outstanding;
                endcase
                if (fifo_wr)  wr_ptr <= wr_ptr + PTR_W'(1);
                if (word_pop) rd_ptr <= rd_ptr + PTR_W'(1);
                // Simultaneous write and pop leave the occupancy unchanged.
                case ({fifo_wr, word_pop})
                    2'b10:   fifo_cnt <= fifo_cnt + (PTR_W+1)'(1);
                    2'b01:   fifo_cnt <= fifo_cnt - (PTR_W+1)'(1);
                    default: fifo_cnt <= fifo_cnt;
                endcase
                if (byte_accept) begin
                    byte_cnt <= byte_cnt + CNT_W'(1);
                    byte_idx <= word_pop ? '0 : byte_idx + BIDX_W'(1);
                end
            end
        end
    end

    // NOTE: the data array has no reset; occupancy and pointers alone decide what is valid.
    always_ff @(posedge clk_original) begin
        if (fifo_wr) fifo_mem[wr_ptr] <= bus.amm_readdata;
    end
endmodule

// File: tb/tb_tx_packet_ddr_stream.sv
// Directed bench for tx_packet_ddr_stream: DDR read responder, TSE FIFO sink and
// a linear sequence of packet commands checked against a bench-side byte model.
module tb_tx_packet_ddr_stream;
    localparam int ADDR_W     = 25;
    localparam int DATA_W     = 256;
    localparam int LEN_W      = 11;
    localparam int MAX_PKT    = 1518;
    localparam int FIFO_WORDS = 8;
    localparam int BPW        = DATA_W / 8;

    logic              clk_original;
    logic              rst_n;
    logic              cmd_send;
    logic [ADDR_W-1:0] start_ram_addr;
    logic              busy, done, len_err;

    tx_packet_ddr_stream_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    tx_packet_ddr_stream #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W),
        .MAX_PKT(MAX_PKT), .FIFO_WORDS(FIFO_WORDS)
    ) dut (
        .clk_original  (clk_original),
        .rst_n         (rst_n),
        .cmd_send      (cmd_send),
        .start_ram_addr(start_ram_addr),
        .busy          (busy),
        .done          (done),
        .len_err       (len_err),
        .bus           (bus)
    );

    initial clk_original = 1'b0;
    always #5 clk_original = ~clk_original;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- DDR memory model ----------------
    logic [ADDR_W-1:0] cur_len_addr = '0;
    logic [LEN_W-1:0]  cur_len_val  = '0;
    logic              stall_mode   = 1'b0;
    logic              rdy_toggle   = 1'b0;
    int                cyc          = 0;

    function automatic logic [7:0] pat(input logic [ADDR_W-1:0] a, input int k);
        logic [7:0] ka;
        ka = k[7:0];
        return a[7:0] * 8'd7 + ka * 8'd13 + 8'h5a;
    endfunction

    function automatic logic [DATA_W-1:0] ddr_word(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] w;
        w = '0;
        for (int k = 0; k < BPW; k++) w[(k / 4) * 32 + (3 - (k % 4)) * 8 +: 8] = pat(a, k);
        if (a == cur_len_addr) w[LEN_W-1:0] = cur_len_val;
        return w;
    endfunction

    // Packet byte n, as it must appear on the TSE side.
    function automatic logic [7:0] exp_byte(input logic [ADDR_W-1:0] base, input int n);
        return pat(base + ADDR_W'(1 + n / BPW), n % BPW);
    endfunction

    typedef struct {
        logic [ADDR_W-1:0] addr;
        int                due;
    } rsp_t;

    rsp_t              rsp_q[$];
    logic [ADDR_W-1:0] rd_log[$];
    int                outstanding  = 0;
    int                max_out      = 0;
    int                rd_hold_viol = 0;

    initial forever begin
        @(posedge clk_original);
        cyc++;
    end

    // Read responder: fixed latency, optional 3-cycle ready stall per read.
    initial begin
        int               stall_cnt;
        logic             rd_held;
        logic [ADDR_W-1:0] held_addr;
        stall_cnt = 0;
        rd_held   = 1'b0;
        held_addr = '0;
        forever begin
            @(negedge clk_original);
            if (rd_held && !(bus.amm_read && bus.amm_addr == held_addr)) rd_hold_viol++;
            if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
                bus.amm_readdata      = ddr_word(rsp_q[0].addr);
                bus.amm_readdatavalid = 1'b1;
                void'(rsp_q.pop_front());
                outstanding--;
            end else begin
                bus.amm_readdata      = '0;
                bus.amm_readdatavalid = 1'b0;
            end
            if (stall_mode && bus.amm_read && stall_cnt < 3) begin
                bus.amm_ready = 1'b0;
                stall_cnt++;
            end else begin
                bus.amm_ready = 1'b1;
            end
            #1;
            rd_held   = bus.amm_read && !bus.amm_ready;
            held_addr = bus.amm_addr;
            if (bus.amm_read && bus.amm_ready) begin
                rsp_q.push_back('{addr: bus.amm_addr, due: cyc + 2});
                rd_log.push_back(bus.amm_addr);
                outstanding++;
                if (outstanding > max_out) max_out = outstanding;
                stall_cnt = 0;
            end
        end
    end

    // ---------------- TSE FIFO sink / monitor ----------------
    logic [9:0] cap_q[$];   // {eop, sop, data} of each accepted byte
    int wren_cycles = 0;
    int done_cycles = 0;
    int lerr_cycles = 0;
    int lerr_busy   = 0;
    int hold_viol   = 0;

    initial begin
        logic       held;
        logic [9:0] held_v;
        held   = 1'b0;
        held_v = '0;
        forever begin
            @(negedge clk_original);
            bus.ff_tx_rdy = rdy_toggle ? ~bus.ff_tx_rdy : 1'b1;
            #1;
            if (held && !(bus.ff_tx_wren && {bus.ff_tx_eop, bus.ff_tx_sop, bus.ff_tx_data} == held_v))
                hold_viol++;
            held   = bus.ff_tx_wren && !bus.ff_tx_rdy;
            held_v = {bus.ff_tx_eop, bus.ff_tx_sop, bus.ff_tx_data};
            if (bus.ff_tx_wren) wren_cycles++;
            if (bus.ff_tx_wren && bus.ff_tx_rdy) cap_q.push_back({bus.ff_tx_eop, bus.ff_tx_sop, bus.ff_tx_data});
            if (done) done_cycles++;
            if (len_err) begin
                lerr_cycles++;
                if (busy) lerr_busy++;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic send_cmd(input logic [ADDR_W-1:0] base, input int len);
        cur_len_addr = base;
        cur_len_val  = len[LEN_W-1:0];
        @(negedge clk_original);
        start_ram_addr = base;
        cmd_send       = 1'b1;
        @(negedge clk_original);
        cmd_send       = 1'b0;
        start_ram_addr = 25'h0abcde;   // must already be latched
    endtask

    task automatic wait_end(input int budget, output int used);
        used = 0;
        do begin
            @(negedge clk_original);
            used++;
        end while (!(done || len_err) && used < budget);
    endtask

    task automatic wait_bytes(input int from, input int nbytes, input int budget, output int used);
        used = 0;
        while ((cap_q.size() - from) < nbytes && used < budget) begin
            @(negedge clk_original);
            used++;
        end
    endtask

    function automatic int reads_at(input int from, input logic [ADDR_W-1:0] a);
        int c;
        c = 0;
        for (int i = from; i < rd_log.size(); i++) if (rd_log[i] == a) c++;
        return c;
    endfunction

    function automatic int eops_since(input int from);
        int c;
        c = 0;
        for (int i = from; i < cap_q.size(); i++) if (cap_q[i][9]) c++;
        return c;
    endfunction

    task automatic check_frame(input string tag, input int from, input logic [ADDR_W-1:0] base, input int len);
        int mism;
        logic [9:0] exp_v;
        mism = 0;
        check({tag, "_bytes"}, 64'(cap_q.size() - from), 64'(len));
        if (cap_q.size() - from >= len) begin
            for (int n = 0; n < len; n++) begin
                exp_v = {(n == len - 1), (n == 0), exp_byte(base, n)};
                if (cap_q[from + n] !== exp_v) mism++;
            end
            check({tag, "_stream_mismatches"}, 64'(mism), 64'd0);
            check({tag, "_sop_first"}, 64'(cap_q[from][8]), 64'd1);
            check({tag, "_eop_last"}, 64'(cap_q[from + len - 1][9]), 64'd1);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int used, cap0, rd0, wren0, done0, lerr0, lb0, size0;
        rst_n          = 1'b0;
        cmd_send       = 1'b0;
        start_ram_addr = '0;

        #12;
        check("rst_busy",       64'(busy), 64'd0);
        check("rst_done",       64'(done), 64'd0);
        check("rst_len_err",    64'(len_err), 64'd0);
        check("rst_amm_read",   64'(bus.amm_read), 64'd0);
        check("rst_amm_addr",   64'(bus.amm_addr), 64'd0);
        check("rst_burstcount", 64'(bus.amm_burstcount), 64'd1);
        check("rst_wren",       64'(bus.ff_tx_wren), 64'd0);
        check("rst_sop_eop",    64'({bus.ff_tx_sop, bus.ff_tx_eop}), 64'd0);
        check("rst_data",       64'(bus.ff_tx_data), 64'd0);
        check("rst_err",        64'(bus.ff_tx_err), 64'd0);
        repeat (2) @(negedge clk_original);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_original);

        // A: 64-byte frame, two payload words, sink always ready
        cap0 = cap_q.size(); rd0 = rd_log.size(); wren0 = wren_cycles; done0 = done_cycles;
        send_cmd(25'h000100, 64);
        wait_end(400, used);
        check("A_timeout", 64'(used < 400), 64'd1);
        @(negedge clk_original);
        check("A_len_reads",     64'(reads_at(rd0, 25'h000100)), 64'd1);
        check("A_payload_reads", 64'(rd_log.size() - rd0 - 1), 64'd2);
        check("A_wren_cycles",   64'(wren_cycles - wren0), 64'd64);
        check("A_done_cycles",   64'(done_cycles - done0), 64'd1);
        check("A_busy_after",    64'(busy), 64'd0);
        check_frame("A", cap0, 25'h000100, 64);

        // B: 33 bytes -> second word contributes only its lane-0 MSB byte
        cap0 = cap_q.size(); rd0 = rd_log.size();
        send_cmd(25'h000200, 33);
        wait_end(400, used);
        check("B_timeout", 64'(used < 400), 64'd1);
        @(negedge clk_original);
        check("B_payload_reads", 64'(rd_log.size() - rd0 - 1), 64'd2);
        check_frame("B", cap0, 25'h000200, 33);
        if (cap_q.size() - cap0 >= 33) begin
            size0 = 32;
            check("B_byte33", 64'(cap_q[cap0 + size0][7:0]), 64'(ddr_word(25'h000202)[31:24]));
        end

        // C: illegal lengths 0 and MAX_PKT+1
        for (int t = 0; t < 2; t++) begin
            cap0 = cap_q.size(); rd0 = rd_log.size(); wren0 = wren_cycles;
            lerr0 = lerr_cycles; lb0 = lerr_busy;
            send_cmd(25'h000600, (t == 0) ? 0 : MAX_PKT + 1);
            wait_end(100, used);
            check($sformatf("C%0d_timeout", t), 64'(used < 100), 64'd1);
            repeat (3) @(negedge clk_original);
            check($sformatf("C%0d_len_err_pulse", t), 64'(lerr_cycles - lerr0), 64'd1);
            check($sformatf("C%0d_busy_at_err", t),   64'(lerr_busy - lb0), 64'd0);
            check($sformatf("C%0d_wren", t),          64'(wren_cycles - wren0), 64'd0);
            check($sformatf("C%0d_reads", t),         64'(rd_log.size() - rd0), 64'd1);
            check($sformatf("C%0d_busy", t),          64'(busy), 64'd0);
        end

        // D: 1024 bytes with sink ready toggling and 3-cycle read stalls
        stall_mode = 1'b1;
        rdy_toggle = 1'b1;
        cap0 = cap_q.size(); rd0 = rd_log.size();
        send_cmd(25'h001000, 1024);
        wait_end(20000, used);
        check("D_timeout", 64'(used < 20000), 64'd1);
        @(negedge clk_original);
        stall_mode = 1'b0;
        rdy_toggle = 1'b0;
        repeat (2) @(negedge clk_original);
        check("D_payload_reads", 64'(rd_log.size() - rd0 - 1), 64'd32);
        check_frame("D", cap0, 25'h001000, 1024);
        check("D_max_outstanding_ok", 64'(max_out <= FIFO_WORDS), 64'd1);
        check("D_tx_hold_viol", 64'(hold_viol), 64'd0);
        check("D_rd_hold_viol", 64'(rd_hold_viol), 64'd0);

        // E1: a second command edge while streaming is ignored
        cap0 = cap_q.size(); rd0 = rd_log.size();
        send_cmd(25'h000300, 100);
        wait_bytes(cap0, 5, 400, used);
        check("E1_start_timeout", 64'(used < 400), 64'd1);
        start_ram_addr = 25'h000380;
        cmd_send       = 1'b1;
        @(negedge clk_original);
        cmd_send       = 1'b0;
        wait_end(400, used);
        check("E1_timeout", 64'(used < 400), 64'd1);
        repeat (10) @(negedge clk_original);
        check("E1_ignored_cmd_reads", 64'(reads_at(rd0, 25'h000380)), 64'd0);
        check("E1_payload_reads", 64'(rd_log.size() - rd0 - 1), 64'd4);
        check("E1_busy_idle", 64'(busy), 64'd0);
        check_frame("E1", cap0, 25'h000300, 100);

        // E2: reset at byte 10 abandons the frame; stale read data is ignored
        cap0 = cap_q.size();
        send_cmd(25'h000400, 200);
        wait_bytes(cap0, 10, 400, used);
        check("E2_start_timeout", 64'(used < 400), 64'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("E2_rst_busy",     64'(busy), 64'd0);
        check("E2_rst_wren",     64'(bus.ff_tx_wren), 64'd0);
        check("E2_rst_sop_eop",  64'({bus.ff_tx_sop, bus.ff_tx_eop}), 64'd0);
        check("E2_rst_data",     64'(bus.ff_tx_data), 64'd0);
        check("E2_rst_amm_read", 64'(bus.amm_read), 64'd0);
        check("E2_rst_amm_addr", 64'(bus.amm_addr), 64'd0);
        check("E2_rst_done",     64'(done), 64'd0);
        repeat (3) @(negedge clk_original);
        rst_n = 1'b1;
        size0 = cap_q.size();
        repeat (20) @(negedge clk_original);
        check("E2_no_eop", 64'(eops_since(cap0)), 64'd0);
        check("E2_stale_ignored_bytes", 64'(cap_q.size() - size0), 64'd0);
        check("E2_stale_ignored_busy", 64'(busy), 64'd0);

        cap0 = cap_q.size(); rd0 = rd_log.size();
        send_cmd(25'h000500, 40);
        wait_end(400, used);
        check("E2_clean_timeout", 64'(used < 400), 64'd1);
        @(negedge clk_original);
        check("E2_clean_payload_reads", 64'(rd_log.size() - rd0 - 1), 64'd2);
        check_frame("E2_clean", cap0, 25'h000500, 40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
